// File: rtl/pipe_pkg.sv
// Shared types and defaults for the async-pipeline sink: FSM state encoding and FIFO sizing helpers.
package pipe_pkg;

    localparam int DW_DEF    = 3;
    localparam int DEPTH_DEF = 4;
    localparam int SYNC_DEF  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } sink_state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/pipe_sink_sync_if.sv
// Bundled-data req/ack input plus valid/ready output of the pipeline sink.
interface pipe_sink_sync_if #(
    parameter int DW = pipe_pkg::DW_DEF
);
    logic          req_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport slave (
        input  req_in, data_in, out_ready,
        output ack_out, out_valid, out_data
    );

    modport master (
        output req_in, data_in, out_ready,
        input  ack_out, out_valid, out_data
    );
endinterface

// File: rtl/pipe_sync_fifo.sv
// Small DEPTH x DW FIFO, head word read straight from the registered array.
// Latency: push visible on head_dat after one clk. Backpressure: full flag; pop while empty ignored.
// Push while full is accepted only together with a pop.
module pipe_sync_fifo
    import pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_dat
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          pop_ok;
    logic          push_ok;

    assign full     = (cnt == CNT_MAX);
    assign empty    = (cnt == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    // Reset clears the array so head_dat reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_sink_sync.sv
// Sink for a 4-phase bundled-data async pipeline feeding a valid/ready FIFO port; TOKEN_CNT_EN adds tok_cnt.
// Latency: req_in rise to ack_out rise = SYNC_STAGES+1 clk edges; word on out_data one clk after capture.
// Backpressure: with the FIFO full the request is left unacknowledged until a slot frees.
module pipe_sink_sync
    import pipe_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    pipe_sink_sync_if.slave     bus
`ifdef TOKEN_CNT_EN
    ,
    output logic [15:0]         tok_cnt
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    sink_state_t            state;
    logic                   ack_q;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // data_in is only trusted on the cycle the synchronised request is first seen high.
    assign push = (state == IDLE) && req_s && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        ack_q <= 1'b1;
                        state <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_out   = ack_q;
    assign bus.out_valid = !empty;
    assign pop           = bus.out_ready && !empty;

    pipe_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (bus.data_in),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head_dat (bus.out_data)
    );

`ifdef TOKEN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_cnt <= '0;
        end else if (push) begin
            tok_cnt <= tok_cnt + 16'd1;
        end
    end
`endif

endmodule
